// File: rtl/writeback_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : writeback_scoreboard
// Purpose  : Merges ALU and long-unit results onto the single register-file
//            write port and stalls decode on hazards against pending long writes.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_scoreboard #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid_i,
    input  logic [4:0]      iss_rs1_addr_i,
    input  logic [4:0]      iss_rs2_addr_i,
    input  logic [4:0]      iss_rd_addr_i,
    input  logic            iss_rd_wen_i,
    input  logic            iss_long_i,
    output logic            iss_stall_o,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_addr_i,
    input  logic [XLEN-1:0] alu_rd_data_i,
    input  logic            lu_valid_i,
    output logic            lu_ready_o,
    input  logic [4:0]      lu_rd_addr_i,
    input  logic [XLEN-1:0] lu_rd_data_i,
    output logic            rd_wen_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [31:0]     pending_o
);

    localparam int c_ptr_w = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(LQ_DEPTH + 1);

    logic [4:0]         lq_addr_q [LQ_DEPTH];
    logic [XLEN-1:0]    lq_data_q [LQ_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;

    logic               rd_wen_q, rd_wen_d;
    logic               rd_long_q, rd_long_d;
    logic [4:0]         rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]    rd_data_q, rd_data_d;
    logic [31:0]        pending_q, pending_d;

    logic w_lq_full;
    logic w_lq_empty;
    logic w_hazard;
    logic w_iss_fire;
    logic w_enq;
    logic w_pop;
    logic w_alu_win;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        if (p == c_ptr_w'(LQ_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_lq_full  = (count_q == c_cnt_w'(LQ_DEPTH));
    assign w_lq_empty = (count_q == '0);

    assign w_hazard    = pending_q[iss_rs1_addr_i] | pending_q[iss_rs2_addr_i]
                       | (iss_rd_wen_i & pending_q[iss_rd_addr_i]);
    assign iss_stall_o = iss_valid_i && (w_hazard || w_lq_full);
    assign w_iss_fire  = iss_valid_i && !iss_stall_o;

    // Long results to x0 complete the handshake but never occupy a slot.
    assign lu_ready_o = !w_lq_full && !rst;
    assign w_enq      = lu_valid_i && lu_ready_o && (lu_rd_addr_i != 5'd0);

    // An ALU write to x0 is not a real write, so it yields the port.
    assign w_alu_win = alu_valid_i && (alu_rd_addr_i != 5'd0);
    assign w_pop     = !w_alu_win && !w_lq_empty;

    always_comb begin
        rd_wen_d  = 1'b0;
        rd_long_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (w_alu_win) begin
            rd_wen_d  = 1'b1;
            rd_addr_d = alu_rd_addr_i;
            rd_data_d = alu_rd_data_i;
        end else if (w_pop) begin
            rd_wen_d  = 1'b1;
            rd_long_d = 1'b1;
            rd_addr_d = lq_addr_q[rd_ptr_q];
            rd_data_d = lq_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = w_enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({w_enq, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Clear lands on the edge the register file captures the long write;
    // the WAW stall keeps it from colliding with a set of the same bit.
    always_comb begin
        pending_d = pending_q;
        if (rd_wen_q && rd_long_q) begin
            pending_d[rd_addr_q] = 1'b0;
        end
        if (w_iss_fire && iss_long_i && iss_rd_wen_i) begin
            pending_d[iss_rd_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_wen_q  <= 1'b0;
            rd_long_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_wen_q  <= rd_wen_d;
            rd_long_q <= rd_long_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            lq_addr_q[wr_ptr_q] <= lu_rd_addr_i;
            lq_data_q[wr_ptr_q] <= lu_rd_data_i;
        end
    end

    assign rd_wen_o  = rd_wen_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;
    assign pending_o = pending_q;

endmodule
`default_nettype wire
